sdram_arbiter: RTL

- Shares one sdram_ctrl instance among NUM_REQ independent requesters (e.g. core data port, VGA/frame reader, debug/test pattern engine).
- Sits between the requesters and sdram_ctrl, in the Clock133 domain.
- Arbitrates round-robin, holds one SDRAM operation outstanding at a time, honours sdram_ctrl Busy (refresh/init), and returns read data to the owning requester after a fixed read latency.

---
 rtl/sdram_ctrl_pkg.sv | 27 ++
 rtl/sdram_arbiter_if.sv | 45 ++++
 rtl/sdram_rr_picker.sv | 38 +++
 rtl/sdram_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_pkg.sv
// ============================================================================
// sdram_ctrl_pkg : shared SDRAM constants, arbiter state type, RR helper
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_ctrl_pkg;

    localparam int SDRAM_DATA_W = 16;
    localparam int SDRAM_ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT_RD = 2'd2
    } sdram_arb_states;

    // Index reached by stepping 'offset' places past 'base' in a ring of n.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
// ============================================================================
// sdram_arbiter_if : requester and sdram_ctrl side signals of sdram_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_arbiter_if
    import sdram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = SDRAM_ADDR_W,
    parameter int DATA_W  = SDRAM_DATA_W
) ();
    localparam int c_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             ReqValid;
    logic [NUM_REQ-1:0]             ReqWrite;
    logic [NUM_REQ-1:0][ADDR_W-1:0] ReqAddress;
    logic [NUM_REQ-1:0][DATA_W-1:0] ReqData;
    logic [NUM_REQ-1:0]             ReqReady;
    logic [NUM_REQ-1:0]             RspValid;
    logic [DATA_W-1:0]              RspData;
    logic [c_ID_W-1:0]              GrantId;
    logic                           CtrlBusy;
    logic [ADDR_W-1:0]              CtrlAddress;
    logic                           CtrlReadReq;
    logic                           CtrlWriteReq;
    logic [DATA_W-1:0]              CtrlDataIn;
    logic [DATA_W-1:0]              CtrlDataOut;

    modport slave (
        input  ReqValid, ReqWrite, ReqAddress, ReqData, CtrlBusy, CtrlDataOut,
        output ReqReady, RspValid, RspData, GrantId,
               CtrlAddress, CtrlReadReq, CtrlWriteReq, CtrlDataIn
    );

    modport master (
        output ReqValid, ReqWrite, ReqAddress, ReqData, CtrlBusy, CtrlDataOut,
        input  ReqReady, RspValid, RspData, GrantId,
               CtrlAddress, CtrlReadReq, CtrlWriteReq, CtrlDataIn
    );

endinterface

`default_nettype wire

// File: rtl/sdram_rr_picker.sv
// ============================================================================
// sdram_rr_picker : combinational round-robin winner search, starting one
//                   place after the pointer and wrapping modulo NUM_REQ
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_rr_picker
    import sdram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]    i_ptr,
    output logic                    o_valid,
    output logic [ID_W-1:0]         o_id
);

    logic [ID_W-1:0] w_idx;

    // Scan farthest-first so the nearest requester after the pointer wins.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        w_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_W'(rr_index(int'(i_ptr), k, NUM_REQ));
            if (i_req[w_idx]) begin
                o_valid = 1'b1;
                o_id    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// sdram_arbiter : round-robin sharing of one sdram_ctrl among NUM_REQ ports,
//                 one operation outstanding. SDRAM_ARB_PERF_CNT_EN adds
//                 GrantCnt/BusyStallCnt performance counters.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbiter
    import sdram_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int READ_LAT = 3,
    parameter int ADDR_W   = SDRAM_ADDR_W,
    parameter int DATA_W   = SDRAM_DATA_W
) (
    input  wire logic          Clock,
    input  wire logic          Rst,
    sdram_arbiter_if.slave     bus
`ifdef SDRAM_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ-1:0][15:0] GrantCnt,
    output logic [15:0]              BusyStallCnt
`endif
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(READ_LAT + 1);

    sdram_arb_states     r_state, w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [c_ID_W-1:0]   r_id;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;

    logic                w_pick_valid;
    logic [c_ID_W-1:0]   w_pick_id;
    logic                w_grant;
    logic                w_accept;
    logic                w_rd_done;
    logic [NUM_REQ-1:0]  w_req_ready;

    sdram_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_ID_W)
    ) u_picker (
        .i_req   (bus.ReqValid),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_id    (w_pick_id)
    );

    always_ff @(posedge Clock) begin
        if (Rst) r_state <= ARB_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        w_grant          = 1'b0;
        w_accept         = 1'b0;
        w_rd_done        = 1'b0;
        bus.CtrlReadReq  = 1'b0;
        bus.CtrlWriteReq = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_grant = 1'b1;
                    w_next  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.CtrlWriteReq = r_write;
                bus.CtrlReadReq  = ~r_write;
                if (!bus.CtrlBusy) begin
                    w_accept = 1'b1;
                    w_next   = r_write ? ARB_IDLE : ARB_WAIT_RD;
                end
            end
            ARB_WAIT_RD: begin
                if (r_cnt == '0) begin
                    w_rd_done = 1'b1;
                    w_next    = ARB_IDLE;
                end
            end
            default: w_next = ARB_IDLE;
        endcase

        w_req_ready     = w_grant ? (NUM_REQ'(1) << w_pick_id) : '0;
        bus.ReqReady    = w_req_ready;
        bus.RspValid    = r_rsp_valid ? (NUM_REQ'(1) << r_id) : '0;
        bus.RspData     = r_rsp_data;
        bus.GrantId     = r_id;
        bus.CtrlAddress = r_addr;
        bus.CtrlDataIn  = r_wdata;

        // Reset aborts at once: no handshake or command escapes this cycle.
        if (Rst) begin
            w_req_ready      = '0;
            bus.ReqReady     = '0;
            bus.RspValid     = '0;
            bus.CtrlReadReq  = 1'b0;
            bus.CtrlWriteReq = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_id        <= '0;
            r_ptr       <= c_ID_W'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_rd_done;
            if (w_rd_done) r_rsp_data <= bus.CtrlDataOut;
            if (w_grant) begin
                r_addr  <= bus.ReqAddress[w_pick_id];
                r_wdata <= bus.ReqData[w_pick_id];
                r_write <= bus.ReqWrite[w_pick_id];
                r_id    <= w_pick_id;
            end
            if (w_accept) begin
                r_ptr <= r_id;
                r_cnt <= c_CNT_W'(READ_LAT - 1);
            end else if (r_state == ARB_WAIT_RD && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

`ifdef SDRAM_ARB_PERF_CNT_EN
    always_ff @(posedge Clock) begin
        if (Rst) begin
            GrantCnt     <= '0;
            BusyStallCnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_req_ready[i] && GrantCnt[i] != 16'hFFFF)
                    GrantCnt[i] <= GrantCnt[i] + 16'd1;
            end
            if (r_state == ARB_ISSUE && bus.CtrlBusy && BusyStallCnt != 16'hFFFF)
                BusyStallCnt <= BusyStallCnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
